// File: rtl/bus_pkg.sv
// Shared definitions for the bus source FIFO: destination field width,
// broadcast ID, destination extraction helper and the status pulse struct.
package bus_pkg;

  localparam logic [7:0] BCAST_ID  = 8'hFF;
  localparam int         DST_W     = 8;
  // Widest packet the helper accepts; narrower packets are zero-extended.
  localparam int         PKT_MAX_W = 64;

  // One-cycle status pulses raised by a FIFO instance.
  typedef struct packed {
    logic overflow;
    logic bad_dst;
    logic underflow;
  } fifo_status_t;

  // Destination ID lives in the top DST_W bits of a pckg_sz-wide packet.
  function automatic logic [DST_W-1:0] get_dst(input logic [PKT_MAX_W-1:0] pkt,
                                               input int pckg_sz);
    return pkt[pckg_sz-1 -: DST_W];
  endfunction

endpackage

// File: rtl/bus_fifo_ram.sv
// Storage for the bus source FIFO: depth x width register array,
// synchronous write, asynchronous (fall-through) read. Never cleared.
module bus_fifo_ram #(
  parameter int W     = 16,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem_reg [DEPTH];

  // Write the addressed entry when the controller accepts a packet.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_reg[waddr] <= wdata;
    end
  end

  assign rdata = mem_reg[raddr];

endmodule

// File: rtl/bus_src_fifo.sv
// Per-device source FIFO feeding one pndng/D_pop lane of the bus.
// Drops packets addressed to this device; first-word fall-through read.
// Optional build macro: BUS_FIFO_STATS_EN enables the wr_cnt/drop_cnt
// saturating counters; without it both ports are tied to zero.
module bus_src_fifo
  import bus_pkg::*;
#(
  parameter int         pckg_sz   = 16,
  parameter int         depth     = 8,
  parameter int         id        = 0,
  parameter int         drvrs     = 4,
  parameter logic [7:0] broadcast = BCAST_ID
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr,
  input  logic [pckg_sz-1:0]         D_in,
  output logic                       full,
  output logic                       pndng,
  output logic [pckg_sz-1:0]         D_pop,
  input  logic                       pop,
  output logic [$clog2(depth+1)-1:0] count,
  output logic                       overflow,
  output logic                       bad_dst,
  output logic                       underflow,
  output logic [15:0]                wr_cnt,
  output logic [15:0]                drop_cnt
);

  localparam int AW = $clog2(depth);
  localparam int CW = $clog2(depth+1);
  localparam logic [DST_W-1:0] ID_L    = DST_W'(id);
  localparam logic [DST_W-1:0] DRVRS_L = DST_W'(drvrs);

  logic [AW-1:0]      rd_ptr_reg, wr_ptr_reg;
  logic [CW-1:0]      count_reg, count_next;
  fifo_status_t       status_reg, status_next;
  logic [DST_W-1:0]   dst;
  logic               dst_known;
  logic               self_dst;
  logic               pop_eff;
  logic               wr_acc;
  logic [pckg_sz-1:0] ram_rdata;

  bus_fifo_ram #(
    .W     (pckg_sz),
    .DEPTH (depth),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr_reg),
    .wdata (D_in),
    .raddr (rd_ptr_reg),
    .rdata (ram_rdata)
  );

  // Broadcast and out-of-range IDs pass unfiltered; only our own ID is dropped.
  assign dst       = get_dst(PKT_MAX_W'(D_in), pckg_sz);
  assign dst_known = (dst != broadcast) && (dst < DRVRS_L);
  assign self_dst  = wr && dst_known && (dst == ID_L);

  assign full    = (count_reg == CW'(depth));
  assign pndng   = (count_reg != '0);
  assign pop_eff = pop && pndng;
  // A pop in the same cycle frees the slot, so a full FIFO still takes the write.
  assign wr_acc  = wr && !self_dst && (!full || pop_eff);

  // Next occupancy and the status pulses for this cycle's events.
  always_comb begin
    count_next            = count_reg + CW'(wr_acc) - CW'(pop_eff);
    status_next           = '0;
    status_next.bad_dst   = self_dst;
    status_next.overflow  = wr && !self_dst && full && !pop_eff;
    status_next.underflow = pop && !pndng;
  end

  // Pointers, occupancy and pulse flags; reset discards contents and ignores wr/pop.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
      status_reg <= '0;
    end else begin
      if (wr_acc)  wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_eff) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg  <= count_next;
      status_reg <= status_next;
    end
  end

  assign D_pop     = pndng ? ram_rdata : '0;
  assign count     = count_reg;
  assign overflow  = status_reg.overflow;
  assign bad_dst   = status_reg.bad_dst;
  assign underflow = status_reg.underflow;

`ifdef BUS_FIFO_STATS_EN
  logic [15:0] wr_cnt_reg, drop_cnt_reg;

  // Saturating accepted / dropped write counters.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_cnt_reg   <= '0;
      drop_cnt_reg <= '0;
    end else begin
      if (wr_acc && wr_cnt_reg != 16'hFFFF)
        wr_cnt_reg <= wr_cnt_reg + 16'd1;
      if ((status_next.overflow || status_next.bad_dst) && drop_cnt_reg != 16'hFFFF)
        drop_cnt_reg <= drop_cnt_reg + 16'd1;
    end
  end

  assign wr_cnt   = wr_cnt_reg;
  assign drop_cnt = drop_cnt_reg;
`else
  assign wr_cnt   = '0;
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_bus_src_fifo.sv
// Directed bench for bus_src_fifo (depth=8, id=1, pckg_sz=16).
module tb_bus_src_fifo;

  localparam int PW    = 16;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          reset;
  logic          wr;
  logic [PW-1:0] D_in;
  logic          full;
  logic          pndng;
  logic [PW-1:0] D_pop;
  logic          pop;
  logic [CW-1:0] count;
  logic          overflow;
  logic          bad_dst;
  logic          underflow;
  logic [15:0]   wr_cnt;
  logic [15:0]   drop_cnt;

  int vectors    = 0;
  int miscompares = 0;

  bus_src_fifo #(
    .pckg_sz   (PW),
    .depth     (DEPTH),
    .id        (1),
    .drvrs     (4),
    .broadcast (8'hFF)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .wr        (wr),
    .D_in      (D_in),
    .full      (full),
    .pndng     (pndng),
    .D_pop     (D_pop),
    .pop       (pop),
    .count     (count),
    .overflow  (overflow),
    .bad_dst   (bad_dst),
    .underflow (underflow),
    .wr_cnt    (wr_cnt),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Apply one cycle of stimulus and sample 1 time unit after the edge.
  task automatic step(input logic w, input logic [PW-1:0] d, input logic p);
    wr   = w;
    D_in = d;
    pop  = p;
    @(posedge clk);
    #1;
    $display("txn rst=%b wr=%b d=%h pop=%b -> count=%0d pndng=%b D_pop=%h full=%b ovf=%b bad=%b udf=%b",
             reset, w, d, p, count, pndng, D_pop, full, overflow, bad_dst, underflow);
    wr  = 1'b0;
    pop = 1'b0;
  endtask

  task automatic chk_flags(input string tag, input logic o, input logic b, input logic u);
    chk({tag, "_ovf"}, 32'(overflow),  32'(o));
    chk({tag, "_bad"}, 32'(bad_dst),   32'(b));
    chk({tag, "_udf"}, 32'(underflow), 32'(u));
  endtask

  initial begin
    reset = 1'b0;
    wr    = 1'b0;
    pop   = 1'b0;
    D_in  = '0;

    // Reset held two cycles with wr asserted: nothing is accepted.
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 16'h0201, 1'b0);
      chk("rst_pndng", 32'(pndng), 0);
      chk("rst_count", 32'(count), 0);
      chk("rst_dpop",  32'(D_pop), 0);
      chk("rst_full",  32'(full),  0);
      chk_flags("rst", 0, 0, 0);
    end
    reset = 1'b1;

    // Fill with 0201..0208.
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 16'(16'h0200 + i), 1'b0);
      chk("fill_count", 32'(count), 32'(i));
      chk("fill_head",  32'(D_pop), 32'h0201);
      chk("fill_full",  32'(full),  32'(i == 8));
    end
    // Ninth write overflows.
    step(1'b1, 16'h0209, 1'b0);
    chk("ovf_count", 32'(count), 8);
    chk_flags("ovf", 1, 0, 0);
    step(1'b0, '0, 1'b0);
    chk_flags("ovf_end", 0, 0, 0);

    // Drain: head walks 0201..0208.
    for (int i = 1; i <= 8; i++) begin
      chk("drain_head", 32'(D_pop), 32'(16'h0200 + i));
      step(1'b0, '0, 1'b1);
    end
    chk("drain_pndng", 32'(pndng), 0);
    chk("drain_count", 32'(count), 0);
    chk_flags("drain", 0, 0, 0);

    // Self-addressed write dropped, broadcast accepted.
    step(1'b1, 16'h01AA, 1'b0);
    chk("self_count", 32'(count), 0);
    chk_flags("self", 0, 1, 0);
    step(1'b1, 16'hFFAA, 1'b0);
    chk_flags("bcast", 0, 0, 0);
    chk("bcast_count", 32'(count), 1);
    chk("bcast_dpop",  32'(D_pop), 32'hFFAA);
    step(1'b0, '0, 1'b1);
    chk("bcast_pop", 32'(count), 0);

    // Full FIFO with simultaneous write and pop.
    for (int i = 1; i <= 8; i++) step(1'b1, 16'(16'h0300 + i), 1'b0);
    chk("sim_full", 32'(full), 1);
    step(1'b1, 16'h0310, 1'b1);
    chk("sim_count", 32'(count), 8);
    chk("sim_head",  32'(D_pop), 32'h0302);
    chk_flags("sim", 0, 0, 0);
    for (int i = 0; i < 7; i++) step(1'b0, '0, 1'b1);
    chk("sim_tail",   32'(D_pop), 32'h0310);
    chk("sim_tail_n", 32'(count), 1);
    step(1'b0, '0, 1'b1);
    chk("sim_empty", 32'(count), 0);

    // Empty corners.
    step(1'b0, '0, 1'b1);
    chk("udf_count", 32'(count), 0);
    chk_flags("udf", 0, 0, 1);
    step(1'b1, 16'h0005, 1'b1);
    chk("udfw_count", 32'(count), 1);
    chk("udfw_dpop",  32'(D_pop), 32'h0005);
    chk_flags("udfw", 0, 0, 1);
    step(1'b0, '0, 1'b0);
    chk_flags("udf_end", 0, 0, 0);

    // Accepted: 8 + 1 + 8 + 1 + 1 = 19; dropped: 1 overflow + 1 self = 2.
`ifdef BUS_FIFO_STATS_EN
    chk("stat_wr",   32'(wr_cnt),   19);
    chk("stat_drop", 32'(drop_cnt), 2);
`else
    chk("stat_wr",   32'(wr_cnt),   0);
    chk("stat_drop", 32'(drop_cnt), 0);
`endif

    // Reset mid-operation discards contents and ignores wr/pop.
    reset = 1'b0;
    step(1'b1, 16'h0207, 1'b1);
    chk("mrst_count", 32'(count), 0);
    chk("mrst_pndng", 32'(pndng), 0);
    chk("mrst_dpop",  32'(D_pop), 0);
    chk_flags("mrst", 0, 0, 0);
    chk("mrst_wr",   32'(wr_cnt),   0);
    chk("mrst_drop", 32'(drop_cnt), 0);
    reset = 1'b1;
    step(1'b1, 16'h0307, 1'b0);
    chk("post_dpop", 32'(D_pop), 32'h0307);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bus_src_fifo.md
Name: bus_src_fifo

Overview:
Per-device source FIFO that sits directly upstream of the bus generator/arbiter. It buffers packets written by a device-side agent and presents them to the bus as one lane of pndng/D_pop, consuming one packet per pop. One instance per device. It also drops self-addressed packets before they reach the bus.

Parameters:
pckg_sz, 16, packet width in bits; upper 8 bits are the destination ID.
depth, 8, FIFO entries; power of two, >= 2.
id, 0, this device's ID (0..drvrs-1).
drvrs, 4, number of devices on the bus.
broadcast, 8'hFF, destination ID meaning all devices.

Ports:
clk  in  1  clock, rising-edge.
reset  in  1  synchronous, active-low reset.
wr  in  1  agent write strobe.
D_in  in  pckg_sz  agent packet; D_in[pckg_sz-1 -: 8] = destination.
full  out  1  FIFO holds depth entries.
pndng  out  1  FIFO non-empty; goes to the bus pndng lane.
D_pop  out  pckg_sz  head packet; goes to the bus D_pop lane.
pop  in  1  bus consumes the head packet.
count  out  $clog2(depth+1)  current occupancy.
overflow  out  1  one-cycle pulse: write dropped because FIFO full.
bad_dst  out  1  one-cycle pulse: write dropped because destination == id.
underflow  out  1  one-cycle pulse: pop with FIFO empty.
wr_cnt  out  16  accepted-write counter (feature-gated).
drop_cnt  out  16  dropped-write counter (feature-gated).

Behaviour:
- Reset: sampled at posedge clk while reset==0. Clears pointers, count, pndng, full, overflow, bad_dst, underflow, wr_cnt and drop_cnt to 0. D_pop reads 0. Storage is not cleared. Reset mid-operation discards all contents at that edge, and wr/pop in that cycle are ignored.
- Read side is first-word fall-through:
  - D_pop = mem[rd_ptr] when count>0, else 0.
  - pndng = (count!=0).
  - full = (count==depth).
- Write acceptance:
  - A write is accepted iff wr && dest!=id && (!full || pop_eff).
  - dest==id: write dropped, bad_dst=1 for the next cycle. bad_dst has precedence over overflow, so overflow is not pulsed.
  - dest==broadcast or dest>=drvrs: write accepted unfiltered.
- Pop: pop_eff = pop && count>0. pop with count==0 is ignored and gives underflow=1 for the next cycle.
- Latency: a write accepted at edge N shows pndng=1 and the packet on D_pop after edge N. A pop at edge M advances D_pop to the next entry after edge M.
- Simultaneous wr and pop:
  - When full: both succeed and count is unchanged, with no overflow.
  - When empty: write accepted, pop ignored (underflow pulses), count becomes 1.
- rd_ptr and wr_ptr are $clog2(depth) bits and wrap naturally from depth-1 to 0. count is tracked separately, never a pointer difference.
- overflow, bad_dst and underflow are registered pulses, high for exactly one cycle per event.

Optional Feature:
BUS_FIFO_STATS_EN
- Defined: wr_cnt increments on every accepted write. drop_cnt increments on every overflow or bad_dst drop. Both are 16-bit, saturate at 16'hFFFF and clear on reset.
- Undefined: no counter logic; wr_cnt and drop_cnt are tied to 0. Ports remain so bench wiring is identical.

Decomposition:
- Shared package bus_pkg holds:
  - BCAST_ID constant (8'hFF);
  - DST_W = 8;
  - function get_dst(pkt) returning pkt[pckg_sz-1 -: DST_W];
  - typedef for the per-instance status pulse struct {overflow, bad_dst, underflow}.
- One sub-module: bus_fifo_ram, a depth x pckg_sz register array with synchronous write and asynchronous read at rd_ptr. The top level holds pointers, count, filter and flags.

Test Plan:
All scenarios use depth=8, id=1, pckg_sz=16.
- Reset: hold reset=0 two cycles with wr=1 -> pndng=0, count=0, D_pop=0, full=0; no flags pulse.
- Fill and drain: write 16'h0201..16'h0208 on consecutive cycles -> full=1 after the 8th write. A 9th write (16'h0209) gives overflow=1 one cycle, count stays 8. Then pop 8 times -> D_pop sequence 0201..0208, pndng=0 after the last pop.
- Self-address filter: write 16'h01AA -> bad_dst pulses, count stays 0. Write 16'hFFAA (broadcast) -> accepted, D_pop=16'hFFAA.
- Full plus simultaneous: at count=8 assert wr (16'h0310) and pop together -> count stays 8, no overflow. After the remaining 7 pops, D_pop=16'h0310.
- Empty corner: at count=0 assert pop alone -> underflow pulses, count 0. Assert wr (16'h0005) and pop together -> count=1, D_pop=16'h0005, underflow pulses.
- Stats (BUS_FIFO_STATS_EN defined): after the scenarios above without intervening reset -> wr_cnt and drop_cnt equal the accepted and dropped totals. Undefined -> both stay 0 throughout.
